// File: rtl/bf_serializer_if.sv
// bf_serializer_if
//   Frame-load and serial-output handshake bundle for bf_serializer.
//   Parameter LENGTH : words per frame (2..32).
//   load_valid/load_ready/PI : parallel frame load (word k at PI[16k+15:16k])
//   SO/so_valid/so_ready/so_last : serial word stream, word 0 first
//   busy : a frame is being shifted or is pending
//   modport slave  : serializer side
//   modport master : producer/consumer side
interface bf_serializer_if #(parameter int LENGTH = 2);
  logic                  load_valid;
  logic                  load_ready;
  logic [16*LENGTH-1:0]  PI;
  logic [15:0]           SO;
  logic                  so_valid;
  logic                  so_ready;
  logic                  so_last;
  logic                  busy;

  modport slave (
    input  load_valid, PI, so_ready,
    output load_ready, SO, so_valid, so_last, busy
  );

  modport master (
    output load_valid, PI, so_ready,
    input  load_ready, SO, so_valid, so_last, busy
  );
endinterface

// File: rtl/bf_serializer.sv
// bf_serializer
//   Parallel-in, serial-out unloader for butterfly result frames. Captures
//   LENGTH 16-bit words in one load and emits them one per transfer, word 0
//   first, on a ready/valid stream. All state honours the clken stall.
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     clken  : clock enable, state freezes while low
//     bus    : bf_serializer_if.slave (load handshake, SO stream, busy)
//
//   Optional feature macro: BF_SERIALIZER_PRELOAD_EN
//     defined   : one-frame hold register, frames stream with no bubble
//     undefined : loads only accepted in IDLE, one bubble between frames
//
//   state | meaning
//   IDLE  | no frame in shreg, SO is 0, ready to load
//   SHIFT | shreg holds a frame, SO = word idx, waiting for transfers
module bf_serializer #(
  parameter int LENGTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clken,
  bf_serializer_if.slave bus
);

  localparam int IW = $clog2(LENGTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_shreg     [LENGTH];
  logic [15:0]   w_shreg_nxt [LENGTH];
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic          w_load;
  logic          w_xfer;
  logic          w_final;

`ifdef BF_SERIALIZER_PRELOAD_EN
  logic [15:0]   r_hold      [LENGTH];
  logic [15:0]   w_hold_nxt  [LENGTH];
  logic          r_hold_full, w_hold_full_nxt;

  assign bus.load_ready = !r_hold_full;
  assign bus.busy       = (r_state == SHIFT) || r_hold_full;
`else
  assign bus.load_ready = (r_state == IDLE);
  assign bus.busy       = (r_state == SHIFT);
`endif

  assign bus.so_valid = (r_state == SHIFT);
  assign bus.SO       = r_shreg[0];
  assign bus.so_last  = (r_state == SHIFT) && (r_idx == LAST_IDX);

  assign w_load  = bus.load_valid && bus.load_ready && clken;
  assign w_xfer  = bus.so_valid && bus.so_ready && clken;
  assign w_final = w_xfer && (r_idx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    for (int k = 0; k < LENGTH; k++) w_shreg_nxt[k] = r_shreg[k];
`ifdef BF_SERIALIZER_PRELOAD_EN
    for (int k = 0; k < LENGTH; k++) w_hold_nxt[k] = r_hold[k];
    w_hold_full_nxt = r_hold_full;
`endif

    case (r_state)
      IDLE: begin
        if (w_load) begin
          for (int k = 0; k < LENGTH; k++) w_shreg_nxt[k] = bus.PI[16*k +: 16];
          w_idx_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_final) begin
          w_idx_nxt = '0;
`ifdef BF_SERIALIZER_PRELOAD_EN
          // A pending hold frame takes precedence; load_ready is low while
          // hold is full, so w_load and r_hold_full never coincide.
          w_hold_full_nxt = 1'b0;
          if (r_hold_full) begin
            for (int k = 0; k < LENGTH; k++) w_shreg_nxt[k] = r_hold[k];
          end else if (w_load) begin
            for (int k = 0; k < LENGTH; k++) w_shreg_nxt[k] = bus.PI[16*k +: 16];
          end else begin
            for (int k = 0; k < LENGTH; k++) w_shreg_nxt[k] = 16'h0000;
            w_state_nxt = IDLE;
          end
`else
          for (int k = 0; k < LENGTH; k++) w_shreg_nxt[k] = 16'h0000;
          w_state_nxt = IDLE;
`endif
        end else begin
          if (w_xfer) begin
            for (int k = 0; k < LENGTH - 1; k++) w_shreg_nxt[k] = r_shreg[k+1];
            w_shreg_nxt[LENGTH-1] = 16'h0000;
            w_idx_nxt = r_idx + IW'(1);
          end
`ifdef BF_SERIALIZER_PRELOAD_EN
          if (w_load) begin
            for (int k = 0; k < LENGTH; k++) w_hold_nxt[k] = bus.PI[16*k +: 16];
            w_hold_full_nxt = 1'b1;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      for (int k = 0; k < LENGTH; k++) r_shreg[k] <= 16'h0000;
`ifdef BF_SERIALIZER_PRELOAD_EN
      for (int k = 0; k < LENGTH; k++) r_hold[k] <= 16'h0000;
      r_hold_full <= 1'b0;
`endif
    end else if (clken) begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      for (int k = 0; k < LENGTH; k++) r_shreg[k] <= w_shreg_nxt[k];
`ifdef BF_SERIALIZER_PRELOAD_EN
      for (int k = 0; k < LENGTH; k++) r_hold[k] <= w_hold_nxt[k];
      r_hold_full <= w_hold_full_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bf_serializer.sv
module tb_bf_serializer;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clken;
  always #5 clk = ~clk;

  bf_serializer_if #(.LENGTH(L)) bus ();

  bf_serializer #(.LENGTH(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clken (clken),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of words still owed to the consumer.
  typedef struct packed {
    logic [15:0] d;
    logic        last;
  } exp_t;
  exp_t q[$];
  exp_t e;

  bit          have_prev = 0;
  logic        p_clken, p_valid, p_ready, p_last, p_lr, p_busy;
  logic [15:0] p_so;
  bit          saw_lr_low = 0;
  bit          rnd_en = 0;

  always @(negedge rst_n) begin
    q.delete();
    have_prev = 0;
  end

  // Monitor: inputs change just after posedge, so at negedge everything is
  // settled and describes what the next posedge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      have_prev = 0;
      chk("rst_so_valid", bus.so_valid, 0);
      chk("rst_SO", bus.SO, 0);
      chk("rst_so_last", bus.so_last, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_load_ready", bus.load_ready, 1);
    end else begin
      chk("so_valid", bus.so_valid, q.size() != 0);
      chk("busy", bus.busy, q.size() != 0);
`ifdef BF_SERIALIZER_PRELOAD_EN
      chk("load_ready", bus.load_ready, q.size() <= L);
`else
      chk("load_ready", bus.load_ready, q.size() == 0);
`endif
      if (!bus.load_ready) saw_lr_low = 1;
      if (!bus.so_valid) begin
        chk("idle_SO", bus.SO, 0);
        chk("idle_so_last", bus.so_last, 0);
      end else if (q.size() != 0) begin
        chk("so_last", bus.so_last, q[0].last);
      end
      if (have_prev) begin
        if (!p_clken) begin
          chk("stall_so_valid", bus.so_valid, p_valid);
          chk("stall_SO", bus.SO, p_so);
          chk("stall_so_last", bus.so_last, p_last);
          chk("stall_load_ready", bus.load_ready, p_lr);
          chk("stall_busy", bus.busy, p_busy);
        end else if (p_valid && !p_ready) begin
          chk("bp_so_valid", bus.so_valid, 1);
          chk("bp_SO", bus.SO, p_so);
        end
      end
      if (bus.so_valid && bus.so_ready && clken) begin
        if (q.size() == 0) begin
          chk("unexpected_word", bus.SO, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("SO", bus.SO, e.d);
        end
      end
      if (bus.load_valid && bus.load_ready && clken)
        for (int k = 0; k < L; k++) q.push_back({bus.PI[16*k +: 16], (k == L-1)});
      have_prev = 1;
      p_clken = clken;
      p_valid = bus.so_valid;
      p_ready = bus.so_ready;
      p_last  = bus.so_last;
      p_lr    = bus.load_ready;
      p_busy  = bus.busy;
      p_so    = bus.SO;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
        bus.so_ready = ($urandom_range(0, 3) != 0);
        clken        = ($urandom_range(0, 9) != 0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the load edge.
  task automatic send_frame(input logic [16*L-1:0] f, input bit keep);
    int n;
    bus.PI = f;
    bus.load_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(bus.load_valid && bus.load_ready && clken) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("load_timeout", 1, 0);
    @(posedge clk);
    #1;
    if (!keep) bus.load_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16*L-1:0] rand_frame();
    logic [16*L-1:0] f;
    for (int k = 0; k < L; k++) f[16*k +: 16] = 16'($urandom);
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [16*L-1:0] fa, fb;
  logic [15:0]     s_so;
  logic            s_valid, s_last, s_lr, s_busy, v1, v2;

  initial begin
    rst_n = 1'b0;
    clken = 1'b1;
    bus.load_valid = 1'b0;
    bus.so_ready = 1'b1;
    bus.PI = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_so_valid", bus.so_valid, 0);
    chk("reset_SO", bus.SO, 0);
    chk("reset_load_ready", bus.load_ready, 1);
    chk("reset_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, words 1..4
    send_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("single_SO", bus.SO, i + 1);
      chk("single_valid", bus.so_valid, 1);
      chk("single_last", bus.so_last, (i == 3));
      @(posedge clk);
      #1;
    end
    chk("single_idle", bus.so_valid, 0);
    drain();

    // Backpressure at idx=1 for 5 cycles
    fa = rand_frame();
    send_frame(fa, 0);
    @(posedge clk);
    #1;
    chk("bp_word1", bus.SO, fa[31:16]);
    bus.so_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_SO", bus.SO, fa[31:16]);
      chk("bp_hold_valid", bus.so_valid, 1);
    end
    bus.so_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_word2", bus.SO, fa[47:32]);
    drain();

    // clken low with load_valid and so_ready both high
    fa = rand_frame();
    send_frame(fa, 0);
    s_so = bus.SO; s_valid = bus.so_valid; s_last = bus.so_last;
    s_lr = bus.load_ready; s_busy = bus.busy;
    clken = 1'b0;
    bus.PI = rand_frame();
    bus.load_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("ce_SO", bus.SO, s_so);
      chk("ce_valid", bus.so_valid, s_valid);
      chk("ce_last", bus.so_last, s_last);
      chk("ce_load_ready", bus.load_ready, s_lr);
      chk("ce_busy", bus.busy, s_busy);
    end
    bus.load_valid = 1'b0;
    clken = 1'b1;
    drain();

    // Back-to-back frames with load_valid held high
    fa = rand_frame();
    fb = rand_frame();
    saw_lr_low = 0;
    fork
      begin
        send_frame(fa, 1);
        send_frame(fb, 0);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.so_valid && bus.so_last) && n < 100) begin
          n++;
          @(negedge clk);
        end
        if (n >= 100) chk("b2b_timeout", 1, 0);
        @(negedge clk);
        v1 = bus.so_valid;
        @(negedge clk);
        v2 = bus.so_valid;
      end
    join
`ifdef BF_SERIALIZER_PRELOAD_EN
    chk("b2b_nogap", v1, 1);
    chk("b2b_lr_drop", saw_lr_low, 1);
`else
    chk("b2b_gap", v1, 0);
`endif
    chk("b2b_resume", v2, 1);
    drain();

    // Asynchronous reset at idx=1, between clock edges
    fa = rand_frame();
    send_frame(fa, 0);
    @(posedge clk);
    #3;
    chk("ar_pre_SO", bus.SO, fa[31:16]);
    rst_n = 1'b0;
    #1;
    chk("ar_so_valid", bus.so_valid, 0);
    chk("ar_SO", bus.SO, 0);
    chk("ar_busy", bus.busy, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fb = rand_frame();
    send_frame(fb, 0);
    chk("ar_restart_SO", bus.SO, fb[15:0]);
    drain();

    // Randomized traffic
    rnd_en = 1;
    for (int i = 0; i < 30; i++) begin
      bit keep;
      keep = (i != 29) && ($urandom_range(0, 1) != 0);
      send_frame(rand_frame(), keep);
      if (!keep) repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_en = 0;
    @(posedge clk);
    #2;
    bus.so_ready = 1'b1;
    clken = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf_serializer.md
# bf_serializer

Parallel-in, serial-out unloader for butterfly result frames. It captures LENGTH 16-bit coefficients in one load and emits them one word per transfer on a ready/valid stream, word 0 first. It sits at the output of the butterfly datapath, draining frames into the coefficient memory write port, which is the consumer end of the butterfly delay lines. Every sequential element honours the shared `clken` stall.

## Interface
- `LENGTH`, default 2: number of 16-bit words per frame; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  active-high clock enable; when low, all state freezes.
- `load_valid`  in  1  a frame is presented on `PI`.
- `load_ready`  out  1  the block can accept a frame.
- `PI`  in  16*LENGTH  frame; word k is `PI[16k+15:16k]`.
- `SO`  out  16  current output word.
- `so_valid`  out  1  `SO` holds a valid word.
- `so_ready`  in  1  consumer accepts `SO`.
- `so_last`  out  1  `SO` is word LENGTH-1 of its frame.
- `busy`  out  1  a frame is being shifted, or a frame is pending.

## Operation
- Load handshake: `load_valid && load_ready && clken`.
- Output transfer: `so_valid && so_ready && clken`.
- State register: `shreg[0..LENGTH-1]`, each 16 bits. `SO` = `shreg[0]`. Word index `idx` is 0..LENGTH-1, width $clog2(LENGTH).
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - `so_valid`=0, `load_ready`=1.
  - On a load: `shreg[k]` ← word k, `idx`←0, go to SHIFT.
- SHIFT:
  - `so_valid`=1.
  - On a transfer with `idx`<LENGTH-1: `shreg[k]`←`shreg[k+1]`, the top word is filled with 0, and `idx`++.
  - On a transfer with `idx`=LENGTH-1 and a next frame available: load that frame, `idx`←0, stay in SHIFT.
  - On a transfer with `idx`=LENGTH-1 and no next frame: clear `shreg` to 0, go to IDLE.
- `so_last` = SHIFT && `idx`==LENGTH-1.
- `so_valid` and `SO` stay stable while `so_ready`=0; there is no retraction.
- `load_ready` and `so_valid` do not depend combinationally on `so_ready` or `load_valid`.
- `clken`=0: no handshake completes, even if valid and ready are both high. Outputs hold their values.

## Timing
- Reset values: `so_valid`=0, `so_last`=0, `SO`=0, `busy`=0, all `shreg` and hold registers 0, state IDLE. `load_ready`=1 in IDLE.
- Reset mid-frame clears all state immediately, discards the frame, and returns to IDLE.
- Load latency: a load accepted at edge N puts word 0 on `SO` with `so_valid`=1 after edge N.
- Throughput: one word per enabled cycle while `so_ready`=1.
- Frame gap without the macro: one IDLE cycle between frames, so the output is 1 bubble per LENGTH words.

## Configuration
- Macro: `BF_SERIALIZER_PRELOAD_EN`.
- Defined:
  - Adds a one-frame hold register and a `hold_full` flag. `load_ready` = !`hold_full`.
  - In SHIFT, a load writes the hold register. The final transfer of a frame moves hold into `shreg`, or moves a frame loaded in the same cycle directly into `shreg`.
  - Back-to-back frames stream with zero bubbles.
  - `busy` = SHIFT || `hold_full`.
- Undefined:
  - No hold register; `load_ready` = IDLE.
  - In SHIFT, a next frame is never available, so the final transfer always returns to IDLE.
  - `busy` = SHIFT.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles → `so_valid`=0, `SO`=0, `load_ready`=1, `busy`=0.
- Single frame, LENGTH=4, `PI`={16'h0004,16'h0003,16'h0002,16'h0001}, `so_ready`=1 → `SO` is 1,2,3,4 on 4 consecutive cycles, `so_last` high only on 4, then IDLE.
- Backpressure: `so_ready`=0 for 5 cycles mid-frame → `SO` and `so_valid` stay frozen, no word is lost or duplicated, and `idx` is unchanged.
- `clken`=0 for 3 cycles while `load_valid` and `so_ready` are both 1 → no load, no transfer, all outputs constant.
- Back-to-back frames A, B with `load_valid` held high:
  - Macro undefined: exactly 1 cycle with `so_valid`=0 between A's last word and B's first word.
  - Macro defined: zero gap, and `load_ready` drops while hold is full.
- Asynchronous `rst_n` pulse at `idx`=1, not aligned to a clock edge → `so_valid`=0 and `SO`=0 immediately; the next load restarts at word 0.
